// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry and fill-engine state encoding.
package vga_pkg;
  localparam int FB_COLS   = 80;
  localparam int FB_ROWS   = 60;
  localparam int FB_CELLS  = FB_COLS * FB_ROWS;
  localparam int FB_ADDR_W = 16;

  typedef enum logic [1:0] {IDLE, WAIT_VBL, FILL, DONE} fill_state_t;
endpackage

// File: rtl/vga_fill_clip.sv
// Clips a rectangle command against the frame buffer; purely combinational.
module vga_fill_clip
  import vga_pkg::*;
#(
  parameter int COLS = FB_COLS,
  parameter int ROWS = FB_ROWS
) (
  input  logic [6:0] x0,
  input  logic [5:0] y0,
  input  logic [6:0] w,
  input  logic [5:0] h,
  output logic [6:0] x_end,
  output logic [5:0] y_end,
  output logic       empty,
  output logic       clipped
);
  logic [7:0] x_sum, y_sum;
  logic       x_over, y_over;

  // 8-bit sums so x0+w / y0+h cannot wrap before the clamp
  assign x_sum  = {1'b0, x0} + {1'b0, w};
  assign y_sum  = {2'b0, y0} + {2'b0, h};
  assign x_over = x_sum > 8'(COLS);
  assign y_over = y_sum > 8'(ROWS);
  // when not over, the sum is <= COLS/ROWS and fits the narrow field
  assign x_end  = x_over ? 7'(COLS) : x_sum[6:0];
  assign y_end  = y_over ? 6'(ROWS) : y_sum[5:0];

  assign empty   = (w == 7'd0) || (h == 6'd0) ||
                   ({1'b0, x0} >= 8'(COLS)) || ({2'b0, y0} >= 8'(ROWS));
  assign clipped = empty || x_over || y_over;
endmodule

// File: rtl/vga_fill_scheduler.sv
// Shares the frame-buffer CPU port between CPU accesses (always first) and a
// rectangle-fill engine that writes one cell per idle cycle.
module vga_fill_scheduler
  import vga_pkg::*;
#(
  parameter int COLS   = FB_COLS,
  parameter int ROWS   = FB_ROWS,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mem_write,
  input  logic              cpu_mem_read,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [7:0]        cpu_write_data,
  output logic [7:0]        cpu_read_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [6:0]        cmd_x0,
  input  logic [5:0]        cmd_y0,
  input  logic [6:0]        cmd_w,
  input  logic [5:0]        cmd_h,
  input  logic [7:0]        cmd_color,
  input  logic              cmd_wait_vblank,
  input  logic              vsync,
  output logic              fb_mem_write,
  output logic [ADDR_W-1:0] fb_address,
  output logic [7:0]        fb_write_data,
  input  logic [7:0]        fb_read_data,
  output logic              busy,
  output logic              done,
  output logic              clipped
);
  fill_state_t state, state_nx;

  logic [6:0]  cx, x0_q, x_end_q;
  logic [5:0]  cy, y_end_q;
  logic [12:0] row_base;
  logic [7:0]  color_q;
  logic        vsync_q, clipped_q;

  logic [6:0]  clip_x_end;
  logic [5:0]  clip_y_end;
  logic        clip_empty, clip_clipped;

  logic accept, cpu_acc, grant, row_end, last_cell, vsync_fall;
  logic [ADDR_W-1:0] fill_addr;

  vga_fill_clip #(.COLS(COLS), .ROWS(ROWS)) u_clip (
    .x0(cmd_x0), .y0(cmd_y0), .w(cmd_w), .h(cmd_h),
    .x_end(clip_x_end), .y_end(clip_y_end),
    .empty(clip_empty), .clipped(clip_clipped)
  );

  assign cmd_ready  = (state == IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign cpu_acc    = cpu_mem_write || cpu_mem_read;
  assign grant      = (state == FILL) && !cpu_acc;
  assign row_end    = ({1'b0, cx} + 8'd1) == {1'b0, x_end_q};
  assign last_cell  = row_end && (({1'b0, cy} + 7'd1) == {1'b0, y_end_q});
  assign vsync_fall = vsync_q && !vsync;
  assign fill_addr  = ADDR_W'(row_base) + ADDR_W'(cx);

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign clipped       = clipped_q;
  assign cpu_read_data = fb_read_data;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (accept) begin
                  if (clip_empty)           state_nx = DONE;
                  else if (cmd_wait_vblank) state_nx = WAIT_VBL;
                  else                      state_nx = FILL;
                end
      WAIT_VBL: if (vsync_fall)             state_nx = FILL;
      FILL:     if (grant && last_cell)     state_nx = DONE;
      DONE:                                 state_nx = IDLE;
      default:                              state_nx = IDLE;
    endcase
  end

  // port mux: CPU owns the port whenever it strobes, fill takes idle cycles
  always_comb begin
    fb_mem_write  = cpu_mem_write;
    fb_address    = cpu_address;
    fb_write_data = cpu_write_data;
    if (!cpu_acc && state == FILL) begin
      fb_mem_write  = 1'b1;
      fb_address    = fill_addr;
      fb_write_data = color_q;
    end
  end

  // command latch, cell walker and vsync edge sampler
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cx        <= '0;
      cy        <= '0;
      x0_q      <= '0;
      x_end_q   <= '0;
      y_end_q   <= '0;
      row_base  <= '0;
      color_q   <= '0;
      clipped_q <= 1'b0;
      vsync_q   <= 1'b1;
    end else begin
      vsync_q <= vsync;
      if (accept) begin
        x0_q      <= cmd_x0;
        x_end_q   <= clip_x_end;
        y_end_q   <= clip_y_end;
        color_q   <= cmd_color;
        clipped_q <= clip_clipped;
        cx        <= cmd_x0;
        cy        <= cmd_y0;
        row_base  <= {7'b0, cmd_y0} * 13'(COLS);
      end else if (grant) begin
        if (row_end) begin
          cx       <= x0_q;
          cy       <= cy + 6'd1;
          row_base <= row_base + 13'(COLS);
        end else begin
          cx <= cx + 7'd1;
        end
      end
    end
  end
endmodule
